// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex glyph table for the seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display word/flags in, board pin drive out.
interface seg7_scan_driver_if;
  logic [31:0] i_bin;
  logic        disp8;
  logic        off;
  logic        dec;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [7:0]  o_an;

  modport master (output i_bin, disp8, off, dec, input o_seg, o_dp, o_an);
  modport slave  (input i_bin, disp8, off, dec, output o_seg, o_dp, o_an);
endinterface

// File: rtl/bin16_to_bcd.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits in 16 shift cycles.
module bin16_to_bcd
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  conv_state_t state_q, state_d;
  logic [35:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [35:0] adj;

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load on start, add-3-then-shift per cycle, one-cycle DONE
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    adj     = sr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {20'b0, value};
          cnt_d   = 5'd16;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        for (int unsigned k = 0; k < 5; k++) begin
          if (adj[16 + 4*k +: 4] >= 4'd5)
            adj[16 + 4*k +: 4] = adj[16 + 4*k +: 4] + 4'd3;
        end
        sr_d  = adj << 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = sr_q[35:16];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode scan driver with per-frame input snapshot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIG_PERIOD = 100_000
) (
  input  logic                clk,
  input  logic                reset_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int unsigned PW = $clog2(DIG_PERIOD);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIG_PERIOD - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   bin_sh_q, bin_sh_d;
  logic          disp8_sh_q, disp8_sh_d;
  logic          off_sh_q, off_sh_d;
  logic          dec_sh_q, dec_sh_d;
  logic          snap_q, snap_d;
  logic [31:0]   digits_q, digits_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    o_an_q, o_an_d;
  logic [6:0]    o_seg_q, o_seg_d;
  logic          o_dp_q, o_dp_d;

  logic        tc;
  logic        dec_mode;
  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [19:0] conv_bcd;
  logic [4:0]  lz_mask;

  bin16_to_bcd u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .value   (bin_sh_q[15:0]),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // All scan, shadow, digit and pin registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      bin_sh_q   <= '0;
      disp8_sh_q <= 1'b0;
      off_sh_q   <= 1'b1;
      dec_sh_q   <= 1'b0;
      snap_q     <= 1'b0;
      digits_q   <= '0;
      mask_q     <= '0;
      o_an_q     <= '1;
      o_seg_q    <= SEG_BLANK;
      o_dp_q     <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      bin_sh_q   <= bin_sh_d;
      disp8_sh_q <= disp8_sh_d;
      off_sh_q   <= off_sh_d;
      dec_sh_q   <= dec_sh_d;
      snap_q     <= snap_d;
      digits_q   <= digits_d;
      mask_q     <= mask_d;
      o_an_q     <= o_an_d;
      o_seg_q    <= o_seg_d;
      o_dp_q     <= o_dp_d;
    end
  end

  // Leading-zero blanking: digit k lit iff some digit at k or above is nonzero
  always_comb begin
    lz_mask    = '0;
    lz_mask[4] = |conv_bcd[19:16];
    lz_mask[3] = lz_mask[4] | (|conv_bcd[15:12]);
    lz_mask[2] = lz_mask[3] | (|conv_bcd[11:8]);
    lz_mask[1] = lz_mask[2] | (|conv_bcd[7:4]);
    lz_mask[0] = 1'b1;
  end

  // Prescaler, scan index, frame snapshot, digit register and pin drive
  always_comb begin
    tc         = (presc_q == PRESC_MAX);
    presc_d    = tc ? '0 : presc_q + PW'(1);
    idx_d      = tc ? idx_q + 3'd1 : idx_q;
    bin_sh_d   = bin_sh_q;
    disp8_sh_d = disp8_sh_q;
    off_sh_d   = off_sh_q;
    dec_sh_d   = dec_sh_q;
    snap_d     = tc && (idx_q == 3'd7);
    if (snap_d) begin
      bin_sh_d   = bus.i_bin;
      disp8_sh_d = bus.disp8;
      off_sh_d   = bus.off;
      dec_sh_d   = bus.dec;
    end

    dec_mode   = !disp8_sh_q && dec_sh_q;
    conv_start = snap_q && dec_mode && !conv_busy;

    digits_d = digits_q;
    mask_d   = mask_q;
    if (snap_q && !dec_mode) begin
      digits_d = bin_sh_q;
      mask_d   = off_sh_q ? 8'h00 : (disp8_sh_q ? 8'hFF : 8'h0F);
    end else if (conv_done) begin
      digits_d = {12'b0, conv_bcd};
      mask_d   = off_sh_q ? 8'h00 : {3'b000, lz_mask};
    end

    // Disabled slots still consume their time slot, keeping brightness uniform
    if (mask_q[idx_q]) begin
      o_an_d  = ~(8'd1 << idx_q);
      o_seg_d = hex2seg(digits_q[{idx_q, 2'b00} +: 4]);
    end else begin
      o_an_d  = '1;
      o_seg_d = SEG_BLANK;
    end
    o_dp_d = !(disp8_sh_q && (idx_q == 3'd4));
  end

  assign bus.o_an  = o_an_q;
  assign bus.o_seg = o_seg_q;
  assign bus.o_dp  = o_dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIG_PERIOD=32 (frame = 256 cycles).
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;

  seg7_scan_driver_if sif ();

  seg7_scan_driver #(.DIG_PERIOD(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after posedge number e (counted from reset release)
  task automatic wait_until(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Sample point in the middle-late part of slot s of frame f
  function automatic int slot_at(input int f, input int s);
    return 256*f + 32*s + 24;
  endfunction

  task automatic check_pins(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    check({tag, "_an"},  32'(sif.o_an),  32'(an));
    check({tag, "_seg"}, 32'(sif.o_seg), 32'(seg));
    check({tag, "_dp"},  32'(sif.o_dp),  32'(dp));
  endtask

  initial begin
    sif.i_bin = 32'h0000_1234;
    sif.disp8 = 1'b0;
    sif.off   = 1'b0;
    sif.dec   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_pins("reset", 8'hFF, 7'h7F, 1'b1);
    check("reset_state", 32'(dut.u_conv.state_q), 32'(IDLE));
    reset_n = 1'b1;
    edge_n  = 0;

    // Frame 0: still blank
    wait_until(100);
    check_pins("pre_bnd_a", 8'hFF, 7'h7F, 1'b1);
    wait_until(255);
    check_pins("pre_bnd_b", 8'hFF, 7'h7F, 1'b1);

    // Frame 1: 4-digit hex 1234
    wait_until(slot_at(1, 0)); check_pins("hex4_s0", 8'hFE, 7'b0011001, 1'b1);
    wait_until(slot_at(1, 1)); check_pins("hex4_s1", 8'hFD, 7'b0110000, 1'b1);
    wait_until(slot_at(1, 4)); check_pins("hex4_s4", 8'hFF, 7'h7F, 1'b1);
    wait_until(slot_at(1, 7)); check_pins("hex4_s7", 8'hFF, 7'h7F, 1'b1);
    sif.disp8 = 1'b1;
    sif.i_bin = 32'hABCD_1234;

    // Frame 2: 8-digit hex with separator on digit 4
    wait_until(slot_at(2, 4)); check_pins("hex8_s4", 8'hEF, 7'b0100001, 1'b0);
    wait_until(slot_at(2, 5)); check_pins("hex8_s5", 8'hDF, 7'b1000110, 1'b1);
    wait_until(slot_at(2, 7)); check_pins("hex8_s7", 8'h7F, 7'b0001000, 1'b1);
    sif.disp8 = 1'b0;
    sif.dec   = 1'b1;
    sif.i_bin = 32'h0000_FFFF;

    // Frame 3: decimal 65535; digit register updates 18 cycles after snapshot
    wait_until(768 + 5);
    check("conv_busy", 32'(dut.u_conv.busy), 32'd1);
    wait_until(768 + 18);
    check("conv_bcd", 32'(dut.u_conv.bcd), 32'h0006_5535);
    check_pins("dec_old", 8'hFE, 7'b0011001, 1'b1);
    wait_until(768 + 19);
    check_pins("dec_new", 8'hFE, 7'b0010010, 1'b1);
    wait_until(slot_at(3, 4)); check_pins("dec_s4", 8'hEF, 7'b0000010, 1'b1);
    wait_until(slot_at(3, 5)); check_pins("dec_s5", 8'hFF, 7'h7F, 1'b1);
    sif.i_bin = 32'h0000_0007;

    // Frame 4: decimal 7 with leading-zero blanking
    wait_until(slot_at(4, 0)); check_pins("lz_s0", 8'hFE, 7'b1111000, 1'b1);
    wait_until(slot_at(4, 1)); check_pins("lz_s1", 8'hFF, 7'h7F, 1'b1);
    wait_until(slot_at(4, 7)); check_pins("lz_s7", 8'hFF, 7'h7F, 1'b1);
    sif.off = 1'b1;

    // Frame 5: blanked; mid-frame input change must not show
    for (int s = 0; s < 8; s++) begin
      wait_until(slot_at(5, s));
      check($sformatf("off_s%0d", s), 32'(sif.o_an), 32'h0000_00FF);
      if (s == 3) begin
        sif.off   = 1'b0;
        sif.dec   = 1'b0;
        sif.i_bin = 32'h0000_1234;
      end
    end

    // Frame 6: mid-frame change now visible
    wait_until(slot_at(6, 0)); check_pins("after_off_s0", 8'hFE, 7'b0011001, 1'b1);
    sif.dec   = 1'b1;
    sif.i_bin = 32'h0000_FFFF;

    // Frame 7: reset 5 cycles into the conversion
    wait_until(1792 + 6);
    check("mid_conv_state", 32'(dut.u_conv.state_q), 32'(SHIFT));
    reset_n = 1'b0;
    #1;
    check_pins("abort", 8'hFF, 7'h7F, 1'b1);
    check("abort_state", 32'(dut.u_conv.state_q), 32'(IDLE));
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    edge_n  = 0;

    // First frame after release converts 65535 cleanly
    wait_until(slot_at(1, 0)); check_pins("rec_s0", 8'hFE, 7'b0010010, 1'b1);
    wait_until(slot_at(1, 3)); check_pins("rec_s3", 8'hF7, 7'b0010010, 1'b1);
    wait_until(slot_at(1, 4)); check_pins("rec_s4", 8'hEF, 7'b0000010, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
